gamepad_btn_cond: RTL and testbench

- Input conditioner between the Gamepad SimIO button bits and the enable inputs of the LED/blink demo blocks.
- Synchronises raw, asynchronous button levels and debounces them per channel.
- Produces stable enables in either level or toggle mode, plus one-cycle press, release and long-press event pulses.
- Output en_o drives the enable inputs of the downstream blink/counter stage directly.

---
 rtl/gamepad_pkg.sv | 14 +
 rtl/btn_debounce.sv | 108 ++++++++++
 rtl/gamepad_btn_cond.sv | 57 +++++
 tb/tb_gamepad_btn_cond.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
// Shared types and constants for the gamepad button conditioner.
package gamepad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } btn_state_e;

  localparam logic MODE_LEVEL  = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, debounce FSM, long-press counter.
module btn_debounce
  import gamepad_pkg::*;
#(
  parameter int DEB_CYCLES  = 20000,
  parameter int LONG_CYCLES = 2000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);

  logic       sync1_q, sync2_q;
  btn_state_e state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic press_q, press_d, release_q, release_d, long_q, long_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!sync2_q) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d    = PRESSED;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d   = DEB_REL;
          deb_cnt_d = DW'(1);
        end else if (hold_cnt_q < LONG_MAX) begin
          // Saturation at LONG_MAX guarantees a single long pulse per press.
          hold_cnt_d = hold_cnt_q + HW'(1);
          long_d     = (hold_cnt_q == LONG_MAX - HW'(1));
        end
      end
      DEB_REL: begin
        if (sync2_q) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stable_o  = (state_q == PRESSED) || (state_q == DEB_REL);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/gamepad_btn_cond.sv
// Per-channel button conditioning with level/toggle enables and event pulses.
module gamepad_btn_cond
  import gamepad_pkg::*;
#(
  parameter int NR_BTN      = 2,
  parameter int DEB_CYCLES  = 20000,
  parameter int LONG_CYCLES = 2000000
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [NR_BTN-1:0] btn_i,
  input  logic              mode_i,
  input  logic              clr_i,
  output logic [NR_BTN-1:0] en_o,
  output logic [NR_BTN-1:0] press_o,
  output logic [NR_BTN-1:0] release_o,
  output logic [NR_BTN-1:0] long_o
);

  logic [NR_BTN-1:0] stable, press;
  logic [NR_BTN-1:0] tog_q, tog_d, en_q, en_d;

  for (genvar g = 0; g < NR_BTN; g++) begin : g_ch
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_deb (
      .clk_i    (clk_i),
      .rst_ni   (rst_in),
      .btn_i    (btn_i[g]),
      .stable_o (stable[g]),
      .press_o  (press[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g])
    );
  end

  // Toggle tracks presses in both modes so a mode switch never glitches en_o.
  always_comb begin
    tog_d = clr_i ? '0 : (tog_q ^ press);
    en_d  = (mode_i == MODE_TOGGLE) ? tog_d : stable;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      tog_q <= '0;
      en_q  <= '0;
    end else begin
      tog_q <= tog_d;
      en_q  <= en_d;
    end
  end

  assign en_o    = en_q;
  assign press_o = press;

endmodule

// File: tb/tb_gamepad_btn_cond.sv
// Directed bench for gamepad_btn_cond with a pulse scoreboard keyed by cycle.
module tb_gamepad_btn_cond;

  localparam int W = 22;  // {cycle[15:0], press[1:0], release[1:0], long[1:0]}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] en, press, rel, lng;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];

  gamepad_btn_cond #(
    .NR_BTN     (2),
    .DEB_CYCLES (4),
    .LONG_CYCLES(10)
  ) dut (
    .clk_i    (clk),
    .rst_in   (rst_n),
    .btn_i    (btn),
    .mode_i   (mode),
    .clr_i    (clr),
    .en_o     (en),
    .press_o  (press),
    .release_o(rel),
    .long_o   (lng)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] l);
    exp_q.push_back({16'(at), p, r, l});
  endtask

  // Press for 'hold' cycles, then release; checks en_o one cycle after press.
  task automatic do_press(input logic [1:0] mask, input int hold, input logic [1:0] en_exp);
    int c;
    c = cyc;
    btn = mask;
    expect_ev(c + 6, mask, 2'b00, 2'b00);
    expect_ev(c + hold + 6, 2'b00, mask, 2'b00);
    wait_until(c + 7);
    check("en_after_press", 32'(en), 32'(en_exp));
    wait_until(c + hold);
    btn = 2'b00;
    wait_until(c + hold + 8);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (rst_n) begin
      a = {16'(cyc), press, rel, lng};
      if ({press, rel, lng} != 6'b0) begin
        if (exp_q.size() == 0) check("pulse_unexpected", 32'(a), 32'(0));
        else begin
          e = exp_q.pop_front();
          check("pulse", 32'(a), 32'(e));
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][W-1:6]) < cyc) begin
        e = exp_q.pop_front();
        check("pulse_missed", 32'(a), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, d, r;
    repeat (3) tick();
    check("reset_en", 32'(en), 0);
    check("reset_pulses", 32'({press, rel, lng}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Level mode: press, long press, release bounce, clean release.
    c = cyc;
    btn = 2'b01;
    expect_ev(c + 6, 2'b01, 2'b00, 2'b00);
    expect_ev(c + 16, 2'b00, 2'b00, 2'b01);
    wait_until(c + 6);
    check("en_before_press", 32'(en), 0);
    wait_until(c + 7);
    check("en_level_press", 32'(en), 32'(2'b01));
    wait_until(c + 20);
    d = cyc;
    btn = 2'b00;
    wait_until(d + 2);
    btn = 2'b01;
    wait_until(d + 8);
    check("en_during_bounce", 32'(en), 32'(2'b01));
    wait_until(d + 25);
    c = cyc;
    btn = 2'b00;
    expect_ev(c + 6, 2'b00, 2'b01, 2'b00);
    wait_until(c + 6);
    check("en_before_release", 32'(en), 32'(2'b01));
    wait_until(c + 7);
    check("en_level_release", 32'(en), 0);

    // Glitch on channel 1: three sampled high cycles are rejected.
    repeat (3) tick();
    c = cyc;
    btn = 2'b10;
    wait_until(c + 3);
    btn = 2'b00;
    wait_until(c + 12);
    check("en_glitch", 32'(en), 0);

    // Toggle mode: three presses give en_o[0] = 1, 0, 1.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mode = 1'b1;
    tick();
    check("en_toggle_start", 32'(en), 0);
    for (int i = 0; i < 3; i++) do_press(2'b01, 8, {1'b0, ~i[0]});
    check("en_toggle_hold", 32'(en), 32'(2'b01));
    mode = 1'b0;
    tick();
    check("en_mode_back_level", 32'(en), 0);

    // clr_i during the press pulse beats the toggle flip.
    mode = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    c = cyc;
    btn = 2'b01;
    expect_ev(c + 6, 2'b01, 2'b00, 2'b00);
    wait_until(c + 6);
    clr = 1'b1;
    wait_until(c + 7);
    clr = 1'b0;
    check("en_clr_wins", 32'(en), 0);
    wait_until(c + 8);
    btn = 2'b00;
    expect_ev(c + 14, 2'b00, 2'b01, 2'b00);
    wait_until(c + 16);
    mode = 1'b0;
    tick();

    // Both channels at once.
    do_press(2'b11, 8, 2'b11);

    // Reset while pressed with hold_cnt = 5, then full re-qualification.
    c = cyc;
    btn = 2'b01;
    expect_ev(c + 6, 2'b01, 2'b00, 2'b00);
    wait_until(c + 11);
    check("en_before_reset", 32'(en), 32'(2'b01));
    rst_n = 1'b0;
    #1;
    check("en_in_reset", 32'(en), 0);
    check("pulses_in_reset", 32'({press, rel, lng}), 0);
    wait_until(c + 13);
    rst_n = 1'b1;
    r = cyc;
    expect_ev(r + 6, 2'b01, 2'b00, 2'b00);
    wait_until(r + 6);
    check("en_requal_pending", 32'(en), 0);
    wait_until(r + 7);
    check("en_requal_done", 32'(en), 32'(2'b01));
    wait_until(r + 8);
    btn = 2'b00;
    expect_ev(r + 14, 2'b00, 2'b01, 2'b00);
    wait_until(r + 20);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
